// File: rtl/vga_pkg.sv
// Shared VGA timing types and default 640x480@60 constants.
// Used by vga_timing_ctrl and pixel_tick_gen.
package vga_pkg;

  typedef logic [9:0] pix_cnt_t;

  localparam int DEF_DIV    = 4;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOT = DEF_H_VIS + DEF_H_FP
                       + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOT = DEF_V_VIS + DEF_V_FP
                       + DEF_V_SYNC + DEF_V_BP;

  // Advance a counter by one, wrapping after last.
  function automatic pix_cnt_t cnt_step(
    input pix_cnt_t cur,
    input pix_cnt_t last
  );
    if (cur == last)
      cnt_step = '0;
    else
      cnt_step = cur + pix_cnt_t'(1);
  endfunction

  // True when lo <= val < hi (10-bit unsigned).
  function automatic logic in_win(
    input pix_cnt_t val,
    input pix_cnt_t lo,
    input pix_cnt_t hi
  );
    in_win = (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider producing a one-clk pixel enable strobe
// every DIV clocks; strobe is decoded from the counter.
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  // Free-running 0..DIV-1 counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      div_cnt <= '0;
    else if (div_cnt == LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel counters, sync, DE, frame pulse.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int DIV    = DEF_DIV,
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int HT_I = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT_I = V_VIS + V_FP + V_SYNC + V_BP;

  localparam pix_cnt_t H_LAST = pix_cnt_t'(HT_I - 1);
  localparam pix_cnt_t V_LAST = pix_cnt_t'(VT_I - 1);

  localparam pix_cnt_t H_VEND = pix_cnt_t'(H_VIS);
  localparam pix_cnt_t V_VEND = pix_cnt_t'(V_VIS);

  localparam pix_cnt_t HS_LO = pix_cnt_t'(H_VIS + H_FP);
  localparam pix_cnt_t HS_HI =
    pix_cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam pix_cnt_t VS_LO = pix_cnt_t'(V_VIS + V_FP);
  localparam pix_cnt_t VS_HI =
    pix_cnt_t'(V_VIS + V_FP + V_SYNC);

  pix_cnt_t h_cnt;
  pix_cnt_t v_cnt;
  pix_cnt_t h_nxt;
  pix_cnt_t v_nxt;
  logic     h_wrap;
  logic     at_origin;

  pixel_tick_gen #(
    .DIV     (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );

  // Next raster position; v steps only on h wrap.
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    h_nxt     = cnt_step(h_cnt, H_LAST);
    v_nxt     = v_cnt;
    if (h_wrap)
      v_nxt   = cnt_step(v_cnt, V_LAST);
    at_origin = (h_nxt == '0) && (v_nxt == '0);
  end

  // Counters and decoded outputs load together from the
  // next position so they line up on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      DE          <= 1'b0;
      frame_start <= 1'b0;
    end else if (p_tick) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      h_sync      <= !in_win(h_nxt, HS_LO, HS_HI);
      v_sync      <= !in_win(v_nxt, VS_LO, VS_HI);
      DE          <= (h_nxt < H_VEND) &&
                     (v_nxt < V_VEND);
      frame_start <= at_origin;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign x_pixel = h_cnt;
  assign y_pixel = v_cnt;

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps on the edge that raises frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      frame_cnt <= '0;
    else if (p_tick && at_origin)
      frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a reduced raster.
// Expected pixels are queued; a monitor checks each tick.
module tb_vga_timing_ctrl;

  localparam int DIV = 4;
  localparam int HV  = 4;
  localparam int HF  = 1;
  localparam int HS  = 2;
  localparam int HB  = 1;
  localparam int VV  = 3;
  localparam int VF  = 1;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FT  = HT * VT;
`ifdef VGA_FRAME_CNT_EN
  localparam int NF  = 257;
`else
  localparam int NF  = 2;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       p_tick;
  logic       h_sync;
  logic       v_sync;
  logic       de;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  exp_t q[$];
  int   vecs;
  int   errs;

  vga_timing_ctrl #(
    .DIV    (DIV),
    .H_VIS  (HV),
    .H_FP   (HF),
    .H_SYNC (HS),
    .H_BP   (HB),
    .V_VIS  (VV),
    .V_FP   (VF),
    .V_SYNC (VS),
    .V_BP   (VB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .p_tick      (p_tick),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .DE          (de),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, req, $time);
    end
  endtask

  // Hand-derived raster: sync windows and DE from segments.
  function automatic exp_t mk(int idx);
    exp_t e;
    int   x;
    int   y;
    x    = idx % HT;
    y    = (idx / HT) % VT;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = !(x >= HV + HF && x < HV + HF + HS);
    e.vs = !(y >= VV + VF && y < VV + VF + VS);
    e.de = (x < HV) && (y < VV);
    e.fs = (x == 0) && (y == 0);
    e.fc = '0;
    return e;
  endfunction

  // Queue n pixels starting at (0,0) after a reset.
  task automatic push_run(int n);
    exp_t e;
    int   fc;
    fc = 0;
    for (int i = 0; i < n; i++) begin
      e = mk(i);
      if (e.fs)
        fc = (fc + 1) % 256;
      e.fc = 8'(fc);
      q.push_back(e);
    end
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_x"},  x_pixel, HT - 1);
    chk({tag, "_y"},  y_pixel, VT - 1);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hs"}, h_sync, 1);
    chk({tag, "_vs"}, v_sync, 1);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_pt"}, p_tick, 0);
`ifdef VGA_FRAME_CNT_EN
    chk({tag, "_fc"}, frame_cnt, 0);
`endif
  endtask

  // Release reset; strobe must appear in the 4th cycle.
  task automatic release_rst(int n);
    @(negedge clk);
    reset_n = 1'b1;
    push_run(n);
    #1 chk("tick_c1", p_tick, 0);
    @(negedge clk) chk("tick_c2", p_tick, 0);
    @(negedge clk) chk("tick_c3", p_tick, 0);
    @(negedge clk) chk("tick_c4", p_tick, 1);
  endtask

  task automatic wait_empty(int lim);
    int n;
    n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Monitor state
  logic       tick_n;
  logic [9:0] lx;
  logic [9:0] ly;
  logic       lhs;
  logic       lvs;
  logic       lde;
  int         gap;
  bit         seen;

  always @(negedge clk) tick_n = p_tick;

  // Checks each update edge against the queue, and that
  // outputs hold between ticks with frame_start low.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset_n) begin
      lx   = 10'(HT - 1);
      ly   = 10'(VT - 1);
      lhs  = 1'b1;
      lvs  = 1'b1;
      lde  = 1'b0;
      gap  = 0;
      seen = 1'b0;
    end else begin
      gap++;
      if (tick_n) begin
        if (seen)
          chk("tick_period", gap, DIV);
        seen = 1'b1;
        gap  = 0;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("x", x_pixel, e.x);
          chk("y", y_pixel, e.y);
          chk("h_sync", h_sync, e.hs);
          chk("v_sync", v_sync, e.vs);
          chk("de", de, e.de);
          chk("frame_start", frame_start, e.fs);
`ifdef VGA_FRAME_CNT_EN
          chk("frame_cnt", frame_cnt, e.fc);
`endif
        end
      end else begin
        chk("hold_x", x_pixel, lx);
        chk("hold_y", y_pixel, ly);
        chk("hold_hs", h_sync, lhs);
        chk("hold_vs", v_sync, lvs);
        chk("hold_de", de, lde);
        chk("fs_pulse", frame_start, 0);
      end
      lx  = x_pixel;
      ly  = y_pixel;
      lhs = h_sync;
      lvs = v_sync;
      lde = de;
    end
  end

  initial begin
    int n;
    vecs    = 0;
    errs    = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("rst");

    n = NF * FT + 2 * HT + 3 + 1;
    release_rst(n);
    wait_empty(n * DIV + 50);

    chk("pre_rst_x", x_pixel, 3);
    chk("pre_rst_y", y_pixel, 2);
    #2 reset_n = 1'b0;
    #1 chk_rst("async_rst");
    repeat (2) @(negedge clk);
    chk_rst("held_rst");

    n = FT + HT + 1;
    release_rst(n);
    wait_empty(n * DIV + 50);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4: clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate).
REQ-002 SHALL have parameters H_VIS, H_FP, H_SYNC, H_BP, defaults 640, 16, 96, 48: horizontal segment lengths in pixels.
REQ-003 SHALL have parameters V_VIS, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical segment lengths in lines.
REQ-004 SHALL have one clock and one reset: reset asynchronous, active-low.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 p_tick  output  1  one-clk pixel-enable strobe, 1 of every DIV clocks.
REQ-008 h_sync  output  1  horizontal sync, active-low.
REQ-009 v_sync  output  1  vertical sync, active-low.
REQ-010 DE  output  1  display enable, drives the RGB gating stage.
REQ-011 x_pixel  output  10  current horizontal count.
REQ-012 y_pixel  output  10  current vertical count.
REQ-013 frame_start  output  1  one-clk pulse on entry to pixel (0,0).

Function
REQ-014 div_cnt SHALL count 0..DIV-1, wrap; p_tick = (div_cnt == DIV-1), combinational from the register.
REQ-015 h_cnt SHALL advance only on p_tick; wraps H_TOT-1 -> 0, where H_TOT = sum of H segments (800).
REQ-016 v_cnt SHALL advance only on p_tick with h_cnt == H_TOT-1; wraps V_TOT-1 -> 0 (V_TOT = 525).
REQ-017 Simultaneous h and v wrap at (799,524) SHALL go to (0,0) in one p_tick.
REQ-018 h_sync, v_sync, DE, frame_start SHALL be registers computed from next-count values, so they align with x_pixel/y_pixel on the same edge; zero extra latency.
REQ-019 h_sync = 0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751).
REQ-020 v_sync = 0 iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491).
REQ-021 DE = 1 iff h_cnt < H_VIS and v_cnt < V_VIS.
REQ-022 frame_start SHALL be 1 for exactly one clk, on the edge loading (0,0); 0 otherwise.
REQ-023 Between p_ticks all outputs except p_tick SHALL hold.
REQ-024 Counter compares SHALL be 10-bit unsigned; no count SHALL exceed its TOT-1.

Reset
REQ-025 reset_n = 0 SHALL immediately force: div_cnt=0, x_pixel=H_TOT-1 (799), y_pixel=V_TOT-1 (524), DE=0, h_sync=1, v_sync=1, frame_start=0.
REQ-026 After release, first p_tick SHALL occur in the 4th clk cycle (div_cnt==3); the following edge loads (0,0) with frame_start=1, DE=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame; restart per REQ-025/026 with no residual state.

Configuration
REQ-028 Macro VGA_FRAME_CNT_EN defined: adds output frame_cnt (8 bits), reset 0, increments on each frame_start, wraps 255 -> 0.
REQ-029 VGA_FRAME_CNT_EN undefined: no frame_cnt port or register; all other behaviour identical.

Structure
REQ-030 Package vga_pkg SHALL hold default timing constants, H_TOT/V_TOT, and typedef pix_cnt_t (logic [9:0]).
REQ-031 Sub-module pixel_tick_gen (div_cnt, p_tick) SHALL be instantiated once; h/v counters and decode stay in vga_timing_ctrl.

Verification
REQ-032 Release reset, 4 clks -> p_tick=1 on 4th cycle; next edge x=0, y=0, DE=1, frame_start=1 for 1 clk.
REQ-033 Run 1 line -> DE high 640 pixels (2560 clks), h_sync low for x=656..751 (96 pixels), line period 3200 clks.
REQ-034 Run 1 frame -> v_sync low for y=490..491 only; DE=0 for y>=480; frame period 1,680,000 clks; frame_start period identical.
REQ-035 At (799,524) + p_tick -> (0,0) in same edge, frame_start=1; at (799,100) -> (0,101), no frame_start.
REQ-036 Assert reset_n at x=300, y=200 -> outputs per REQ-025 without waiting for clk; release -> REQ-032 repeats.
REQ-037 VGA_FRAME_CNT_EN defined, run 257 frames -> frame_cnt 0,1,...,255,0,1; undefined -> build passes without the port.
